// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: stage-buffer states, reset PC and the
// per-stage payload layouts every stage packs and unpacks identically.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } stage_st_t;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  localparam int unsigned STAGE_DATA_W = 160;

  // ID/EX payload field offsets (LSB positions inside the 160-bit bus)
  localparam int unsigned IDEX_INSTR_LSB = 0;
  localparam int unsigned IDEX_RS_LSB    = 32;
  localparam int unsigned IDEX_RT_LSB    = 64;
  localparam int unsigned IDEX_IMM_LSB   = 96;
  localparam int unsigned IDEX_CTRL_LSB  = 128;

  typedef struct packed {
    logic [31:0] ctrl;
    logic [31:0] imm;
    logic [31:0] rt;
    logic [31:0] rs;
    logic [31:0] instr;
  } idex_t;

endpackage

// File: rtl/pipe_entry.sv
// One pipeline slot: PC + payload register with load enable and async clear.
module pipe_entry #(
  parameter int unsigned  W       = 192,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= CLR_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register with valid/ready handshake, optional skid
// entry, flush-to-bubble (keeping the incoming PC) and a flush-drop counter.
module pipe_stage_buf
  import cpu_pkg::stage_st_t, cpu_pkg::ST_EMPTY, cpu_pkg::ST_FULL, cpu_pkg::ST_SKID;
#(
  parameter int unsigned     DATA_W   = 160,
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(cpu_pkg::RESET_PC),
  parameter bit              SKID     = 1'b1,
  parameter int unsigned     CNT_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam int unsigned       ENT_W   = PC_W + DATA_W;
  localparam logic [CNT_W:0]    CNT_MAX = {1'b0, {CNT_W{1'b1}}};

  stage_st_t        state;
  logic             inReadyQ;
  logic             acc;
  logic             fire;
  logic             mainLd;
  logic [ENT_W-1:0] mainD;
  logic [ENT_W-1:0] mainQ;
  logic [ENT_W-1:0] skidQ;
  logic [1:0]       liveCnt;
  logic [CNT_W:0]   dropSum;
  logic [CNT_W-1:0] dropNext;

  assign acc      = in_valid & in_ready;
  assign fire     = out_valid & out_ready;
  assign out_pc   = mainQ[ENT_W-1:DATA_W];
  assign out_data = mainQ[DATA_W-1:0];
  assign in_ready = SKID ? inReadyQ : (~out_valid | out_ready);

  // Main slot data source: new input, bubble with held/incoming PC, or skid promotion
  always_comb begin
    mainLd = 1'b0;
    mainD  = {in_pc, in_data};
    if (flush) begin
      mainLd = 1'b1;
      mainD  = {in_pc, {DATA_W{1'b0}}};
    end else begin
      case (state)
        ST_EMPTY: mainLd = acc;
        ST_FULL: begin
          if (fire) begin
            mainLd = 1'b1;
            if (!acc) mainD = {out_pc, {DATA_W{1'b0}}};
          end
        end
        ST_SKID: begin
          if (fire) begin
            mainLd = 1'b1;
            mainD  = skidQ;
          end
        end
        default: mainLd = 1'b0;
      endcase
    end
  end

  pipe_entry #(
    .W      (ENT_W),
    .CLR_VAL({RESET_PC, {DATA_W{1'b0}}})
  ) uMain (
    .clk  (clk),
    .reset(reset),
    .load (mainLd),
    .d    (mainD),
    .q    (mainQ)
  );

  generate
    if (SKID) begin : gSkid
      logic skidLd;
      assign skidLd = ~flush & (state == ST_FULL) & ~fire & acc;
      pipe_entry #(
        .W      (ENT_W),
        .CLR_VAL('0)
      ) uSkid (
        .clk  (clk),
        .reset(reset),
        .load (skidLd),
        .d    ({in_pc, in_data}),
        .q    (skidQ)
      );
    end else begin : gNoSkid
      assign skidQ = '0;
    end
  endgenerate

  // Live entries thrown away by a flush, added with saturation
  always_comb begin
    liveCnt = 2'd0;
    if (state == ST_FULL) liveCnt = 2'd1;
    if (state == ST_SKID) liveCnt = 2'd2;
    dropSum  = {1'b0, drop_cnt} + (CNT_W+1)'(liveCnt);
    dropNext = (dropSum > CNT_MAX) ? '1 : dropSum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      inReadyQ  <= 1'b1;
      drop_cnt  <= '0;
    end else if (flush) begin
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      inReadyQ  <= 1'b1;
      drop_cnt  <= dropNext;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (acc) begin
            state     <= ST_FULL;
            out_valid <= 1'b1;
          end
        end
        ST_FULL: begin
          if (fire && !acc) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
          end else if (!fire && acc) begin
            state    <= ST_SKID;
            inReadyQ <= 1'b0;
          end
        end
        ST_SKID: begin
          if (fire) begin
            state    <= ST_FULL;
            inReadyQ <= 1'b1;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          out_valid <= 1'b0;
          inReadyQ  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Randomized and directed checks of pipe_stage_buf (skid build and a
// single-entry, 2-bit-counter build) against a queue-based reference model.
module tb_pipe_stage_buf;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic [31:0]  in_pc = '0;
  logic [159:0] in_data = '0;
  logic         out_ready = 1'b0;

  logic         aInReady, aOutValid, bInReady, bOutValid;
  logic [31:0]  aOutPc, bOutPc;
  logic [159:0] aOutData, bOutData;
  logic [7:0]   aDrop;
  logic [1:0]   bDrop;

  always #5 clk = ~clk;

  pipe_stage_buf uDutA (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(aInReady), .in_pc(in_pc), .in_data(in_data),
    .out_valid(aOutValid), .out_ready(out_ready), .out_pc(aOutPc),
    .out_data(aOutData), .drop_cnt(aDrop)
  );

  pipe_stage_buf #(.SKID(1'b0), .CNT_W(2)) uDutB (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(bInReady), .in_pc(in_pc), .in_data(in_data),
    .out_valid(bOutValid), .out_ready(out_ready), .out_pc(bOutPc),
    .out_data(bOutData), .drop_cnt(bDrop)
  );

  // Which build is currently being compared
  bit           sel = 1'b0;
  logic         obsReady, obsValid;
  logic [31:0]  obsPc;
  logic [159:0] obsData;
  logic [7:0]   obsDrop;
  assign obsReady = sel ? bInReady  : aInReady;
  assign obsValid = sel ? bOutValid : aOutValid;
  assign obsPc    = sel ? bOutPc    : aOutPc;
  assign obsData  = sel ? bOutData  : aOutData;
  assign obsDrop  = sel ? 8'(bDrop) : aDrop;

  // Reference model: a FIFO of live instructions plus the PC shown when empty
  typedef struct {
    logic [31:0]  pc;
    logic [159:0] data;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] mLastPc;
  int          mDrop;
  int          mMax;
  bit          mComb;
  int          nChecks = 0;
  int          nFail = 0;

  function automatic bit mInReady();
    if (mComb) return (mq.size() == 0) || out_ready;
    return mq.size() < 2;
  endfunction

  task automatic modelReset();
    mq.delete();
    mLastPc = 32'h0000_3000;
    mDrop   = 0;
  endtask

  task automatic modelStep();
    bit   rdy;
    bit   fire;
    ent_t e;
    rdy  = mInReady();
    fire = (mq.size() != 0) && out_ready;
    if (flush) begin
      mDrop = (mDrop + mq.size() > mMax) ? mMax : mDrop + mq.size();
      mq.delete();
      mLastPc = in_pc;
    end else begin
      if (fire) begin
        mLastPc = mq[0].pc;
        void'(mq.pop_front());
      end
      if (in_valid && rdy) begin
        e.pc   = in_pc;
        e.data = in_data;
        mq.push_back(e);
      end
    end
  endtask

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    nChecks++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    check({tag, ".in_ready"},  160'(obsReady), 160'(mInReady()));
    check({tag, ".out_valid"}, 160'(obsValid), 160'(mq.size() != 0));
    check({tag, ".out_pc"},    160'(obsPc),    160'((mq.size() != 0) ? mq[0].pc : mLastPc));
    check({tag, ".out_data"},  obsData,        (mq.size() != 0) ? mq[0].data : 160'd0);
    check({tag, ".drop_cnt"},  160'(obsDrop),  160'(mDrop));
  endtask

  // Inputs are set by the caller just after a rising edge
  task automatic cyc(input string tag);
    #1;
    checkAll(tag);
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic idle();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    idle();
    reset = 1'b0;
    #1;
    modelReset();
    checkAll("reset");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic stream8();
    for (int i = 1; i <= 8; i++) begin
      in_valid  = 1'b1;
      in_pc     = 32'h3000 + 32'(4 * i);
      in_data   = 160'(i);
      out_ready = 1'b1;
      cyc("stream");
    end
    in_valid = 1'b0;
    cyc("stream.drain");
    cyc("stream.drain");
  endtask

  task automatic randomRun(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 24) == 0);
      in_pc     = $urandom;
      in_data   = {$urandom, $urandom, $urandom, $urandom, $urandom};
      cyc("random");
    end
    idle();
  endtask

  initial begin
    // Skid build (two entries, registered in_ready, 8-bit counter)
    sel   = 1'b0;
    mComb = 1'b0;
    mMax  = 255;
    #1 reset = 1'b0;
    #1;
    modelReset();
    checkAll("por");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    stream8();

    // Backpressure: A and B accepted, C held off while the skid is occupied
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_pc = 32'h3100; in_data = {5{$urandom}}; cyc("bp.A");
    in_pc = 32'h3104; in_data = {5{$urandom}}; cyc("bp.B");
    in_pc = 32'h3108; in_data = {5{$urandom}}; cyc("bp.C");
    #1;
    check("bp.skid_in_ready", 160'(obsReady), 160'(0));
    out_ready = 1'b1;
    cyc("bp.relA");
    cyc("bp.relB");
    in_valid = 1'b0;
    cyc("bp.relC");
    cyc("bp.idle");

    // Flush while both entries are live
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_pc = 32'h3200; in_data = {5{$urandom}}; cyc("fl2.fill");
    in_pc = 32'h3204; in_data = {5{$urandom}}; cyc("fl2.fill");
    flush = 1'b1;
    in_pc = 32'h3010; in_data = {5{$urandom}}; cyc("fl2.flush");
    idle();
    #1;
    check("fl2.out_valid", 160'(obsValid), 160'(0));
    check("fl2.out_data",  obsData,        160'(0));
    check("fl2.out_pc",    160'(obsPc),    160'(32'h3010));
    check("fl2.drop_cnt",  160'(obsDrop),  160'(2));
    cyc("fl2.after");

    // Flush and accept together from EMPTY: entry dropped, counter unchanged
    flush    = 1'b1;
    in_valid = 1'b1;
    in_pc    = 32'h3020;
    in_data  = {5{$urandom}};
    cyc("flacc");
    idle();
    #1;
    check("flacc.out_valid", 160'(obsValid), 160'(0));
    check("flacc.drop_cnt",  160'(obsDrop),  160'(2));
    cyc("flacc.after");

    randomRun(400);

    // Asynchronous reset mid-stream, checked before any clock edge
    in_valid = 1'b1; out_ready = 1'b0;
    in_pc = 32'h3300; in_data = {5{$urandom}};
    cyc("arst.fill");
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("arst.out_valid", 160'(obsValid), 160'(0));
    check("arst.out_pc",    160'(obsPc),    160'(32'h3000));
    check("arst.drop_cnt",  160'(obsDrop),  160'(0));
    modelReset();
    checkAll("arst");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    randomRun(100);

    // Single-entry build with a 2-bit counter
    sel   = 1'b1;
    mComb = 1'b1;
    mMax  = 3;
    doReset();
    stream8();

    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_pc = 32'h3400; in_data = {5{$urandom}}; cyc("b.fl.fill");
    in_pc = 32'h3404; in_data = {5{$urandom}}; cyc("b.fl.stall");
    flush = 1'b1;
    in_pc = 32'h3010; cyc("b.fl.flush");
    idle();
    #1;
    check("b.fl.out_pc",   160'(obsPc),   160'(32'h3010));
    check("b.fl.drop_cnt", 160'(obsDrop), 160'(1));
    cyc("b.fl.after");

    for (int i = 0; i < 5; i++) begin
      flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
      in_pc = $urandom; in_data = {5{$urandom}};
      cyc("b.sat.fill");
      flush = 1'b1; in_valid = 1'b0;
      cyc("b.sat.flush");
    end
    idle();
    #1;
    check("b.sat.drop_cnt", 160'(obsDrop), 160'(3));
    cyc("b.sat.after");

    randomRun(300);

    $display("%0d/%0d checks passed", nChecks - nFail, nChecks);
    $finish;
  end

endmodule
